// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a shared single-port memory.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise the data port wins.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_ren,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_data,
    output logic                  i_stall,
    input  logic                  d_ren,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_din,
    output logic [DATA_WIDTH-1:0] d_dout,
    output logic                  d_stall,
    output logic                  m_cs,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_dout,
    input  logic [DATA_WIDTH-1:0] m_din,
    input  logic                  m_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    logic   last_d;     // 1 when the most recent grant went to the data port
    logic   d_req;
    logic   grant_d;

    assign d_req = d_ren | d_wen;

`ifdef ARB_ROUND_ROBIN_EN
    assign grant_d = d_req & (~i_ren | ~last_d);
`else
    assign grant_d = d_req;
`endif

    // Stalls drop only during the single DONE cycle of the port just served
    assign i_stall = i_ren & ~((state == DONE) & ~last_d);
    assign d_stall = d_req & ~((state == DONE) & last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
            m_cs   <= 1'b0;
            m_we   <= 1'b0;
            m_addr <= '0;
            m_dout <= '0;
            i_data <= '0;
            d_dout <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state  <= BUSY_D;
                        last_d <= 1'b1;
                        m_cs   <= 1'b1;
                        m_we   <= d_wen;
                        m_addr <= d_addr;
                        m_dout <= d_din;
                    end else if (i_ren) begin
                        state  <= BUSY_I;
                        last_d <= 1'b0;
                        m_cs   <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= i_addr;
                    end
                end
                BUSY_I: begin
                    if (m_ack) begin
                        i_data <= m_din;
                        m_cs   <= 1'b0;
                        state  <= DONE;
                    end
                end
                BUSY_D: begin
                    // Access completes even if the requester has since withdrawn
                    if (m_ack) begin
                        if (!m_we) begin
                            d_dout <= m_din;
                        end
                        m_cs  <= 1'b0;
                        m_we  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_ren;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_data;
    logic          i_stall;
    logic          d_ren;
    logic          d_wen;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_din;
    logic [DW-1:0] d_dout;
    logic          d_stall;
    logic          m_cs;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dout;
    logic [DW-1:0] m_din;
    logic          m_ack;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_i;
    logic [DW-1:0] exp_d;
    logic          exp_grant_d;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_ren   (i_ren),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .i_stall (i_stall),
        .d_ren   (d_ren),
        .d_wen   (d_wen),
        .d_addr  (d_addr),
        .d_din   (d_din),
        .d_dout  (d_dout),
        .d_stall (d_stall),
        .m_cs    (m_cs),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_dout  (m_dout),
        .m_din   (m_din),
        .m_ack   (m_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set afterwards apply to the following edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; i_ren = 1'b0; i_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
        d_addr = '0; d_din = '0; m_din = '0; m_ack = 1'b0;

        // Reset values, stall follows request during reset
        tick(); tick();
        i_ren = 1'b1; settle();
        check("rst_i_stall_req", 64'(i_stall), 64'd1);
        i_ren = 1'b0; settle();
        check("rst_m_cs",   64'(m_cs),   64'd0);
        check("rst_m_we",   64'(m_we),   64'd0);
        check("rst_m_addr", 64'(m_addr), 64'd0);
        check("rst_m_dout", 64'(m_dout), 64'd0);
        check("rst_i_data", 64'(i_data), 64'd0);
        check("rst_d_dout", 64'(d_dout), 64'd0);
        check("rst_i_stall_idle", 64'(i_stall), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_m_cs", 64'(m_cs), 64'd0);

        // Instruction read: ack 3 cycles after m_cs rises, stall low only in cycle 5
        i_ren = 1'b1; i_addr = 32'h10; m_din = 32'hDEADBEEF; settle();
        for (int c = 0; c <= 5; c++) begin
            if (c == 4) m_ack = 1'b1; else m_ack = 1'b0;
            settle();
            check($sformatf("ird_i_stall_c%0d", c), 64'(i_stall), (c == 5) ? 64'd0 : 64'd1);
            if (c >= 1 && c <= 4) begin
                check($sformatf("ird_m_cs_c%0d", c), 64'(m_cs), 64'd1);
                check($sformatf("ird_m_addr_c%0d", c), 64'(m_addr), 64'h10);
            end
            if (c < 5) tick();
        end
        check("ird_i_data", 64'(i_data), 64'hDEADBEEF);
        check("ird_done_m_cs", 64'(m_cs), 64'd0);
        exp_i = 32'hDEADBEEF;
        i_ren = 1'b0;
        tick();
        check("ird_idle_m_cs", 64'(m_cs), 64'd0);

        // Stray ack in IDLE is ignored
        m_din = 32'h11111111; m_ack = 1'b1;
        tick();
        m_ack = 1'b0; tick();
        check("stray_m_cs",   64'(m_cs),   64'd0);
        check("stray_i_data", 64'(i_data), 64'(exp_i));
        check("stray_d_dout", 64'(d_dout), 64'd0);

        // Data write with d_ren also high: treated as write, outputs held until ack
        d_wen = 1'b1; d_ren = 1'b1; d_addr = 32'h40; d_din = 32'h12345678;
        tick();
        d_din = 32'h0BADF00D; m_din = 32'hBAD0BAD0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("wr_m_cs_c%0d", c),   64'(m_cs),   64'd1);
            check($sformatf("wr_m_we_c%0d", c),   64'(m_we),   64'd1);
            check($sformatf("wr_m_addr_c%0d", c), 64'(m_addr), 64'h40);
            check($sformatf("wr_m_dout_c%0d", c), 64'(m_dout), 64'h12345678);
            check($sformatf("wr_d_stall_c%0d", c), 64'(d_stall), 64'd1);
            if (c == 2) m_ack = 1'b1;
            tick();
        end
        m_ack = 1'b0; settle();
        check("wr_done_d_stall", 64'(d_stall), 64'd0);
        check("wr_done_m_cs",    64'(m_cs),    64'd0);
        check("wr_no_capture",   64'(d_dout),  64'd0);
        d_wen = 1'b0; d_ren = 1'b0;
        tick();
        check("wr_idle_m_cs", 64'(m_cs), 64'd0);

        // Write withdrawn mid-access still completes through DONE
        d_wen = 1'b1; d_addr = 32'h44; d_din = 32'hA5A5A5A5;
        tick();
        d_wen = 1'b0; settle();
        check("wd_d_stall_busy", 64'(d_stall), 64'd0);
        check("wd_m_cs",   64'(m_cs),   64'd1);
        check("wd_m_we",   64'(m_we),   64'd1);
        check("wd_m_dout", 64'(m_dout), 64'hA5A5A5A5);
        tick();
        check("wd_m_cs_hold", 64'(m_cs), 64'd1);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        d_ren = 1'b1; settle();
        check("wd_done_d_stall", 64'(d_stall), 64'd0);
        check("wd_done_m_cs",    64'(m_cs),    64'd0);
        d_ren = 1'b0;
        tick();
        check("wd_idle_m_cs", 64'(m_cs), 64'd0);

        // Contention: four back-to-back transactions from a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        exp_i = '0; exp_d = '0;
        i_ren = 1'b1; i_addr = 32'h100; d_ren = 1'b1; d_addr = 32'h200;
        for (int n = 0; n < 4; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_grant_d = (n % 2 == 0);
`else
            exp_grant_d = 1'b1;
`endif
            tick();
            check($sformatf("arb_m_addr_t%0d", n), 64'(m_addr), exp_grant_d ? 64'h200 : 64'h100);
            m_din = 32'h1000 + 32'(n); m_ack = 1'b1;
            tick();
            m_ack = 1'b0; settle();
            if (exp_grant_d) exp_d = 32'h1000 + 32'(n); else exp_i = 32'h1000 + 32'(n);
            check($sformatf("arb_i_stall_t%0d", n), 64'(i_stall), exp_grant_d ? 64'd1 : 64'd0);
            check($sformatf("arb_d_stall_t%0d", n), 64'(d_stall), exp_grant_d ? 64'd0 : 64'd1);
            check($sformatf("arb_i_data_t%0d", n), 64'(i_data), 64'(exp_i));
            check($sformatf("arb_d_dout_t%0d", n), 64'(d_dout), 64'(exp_d));
            tick();
        end

        // Reset during BUSY_D, then a late ack
        i_ren = 1'b0; d_ren = 1'b1; d_addr = 32'h80;
        tick();
        check("rb_busy_m_cs", 64'(m_cs), 64'd1);
        rst = 1'b1;
        tick();
        check("rb_m_cs",    64'(m_cs),    64'd0);
        check("rb_d_stall", 64'(d_stall), 64'd1);
        check("rb_d_dout",  64'(d_dout),  64'd0);
        rst = 1'b0; d_ren = 1'b0; m_din = 32'hCAFEF00D; m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        d_ren = 1'b1; settle();
        check("rb_ack_m_cs",    64'(m_cs),    64'd0);
        check("rb_ack_d_dout",  64'(d_dout),  64'd0);
        check("rb_ack_d_stall", 64'(d_stall), 64'd1);
        d_ren = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
